// File: rtl/lsu_pkg.sv
// Shared types and helpers for the dmem load/store unit.
// - lsu_state_e : FSM states of dmem_lsu
// - F3_*        : RV32 load/store funct3 encodings
// - size_bytes  : access width in bytes for a funct3
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACC1,
        ACC2,
        RESP
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Illegal encodings fall into the word case; they never reach an access.
    function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lsu_lane_align.sv
// Combinational lane logic for dmem_lsu.
// - off, funct3       : byte offset and funct3 of the current op
// - st_hi, st_wdata   : select second (upper word) half of a store; store data
// - st_be, st_data    : byte enables and lane-shifted data for that half
// - ld_hi, ld_rdata   : select second half of a load; dmem read data
// - merge_in/out      : load merge register, current and next value
// - ext_data          : merge_in sign/zero-extended per funct3
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    input  logic        st_hi,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_data,
    input  logic        ld_hi,
    input  logic [31:0] ld_rdata,
    input  logic [31:0] merge_in,
    output logic [31:0] merge_out,
    output logic [31:0] ext_data
);

    logic [3:0]  size_mask;
    logic [7:0]  be_wide;
    logic [63:0] data_wide;
    logic [4:0]  lo_sh;
    logic [5:0]  hi_sh;

    always_comb begin
        case (size_bytes(funct3))
            3'd1:    size_mask = 4'b0001;
            3'd2:    size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase

        // Shift across a two-word window: low half feeds the first access,
        // high half feeds the second access of a split op.
        lo_sh     = {off, 3'b000};
        hi_sh     = 6'd32 - {1'b0, off, 3'b000};
        be_wide   = {4'b0000, size_mask} << off;
        data_wide = {32'h0, st_wdata} << lo_sh;
        st_be     = st_hi ? be_wide[7:4]     : be_wide[3:0];
        st_data   = st_hi ? data_wide[63:32] : data_wide[31:0];

        merge_out = ld_hi ? (merge_in | (ld_rdata << hi_sh)) : (ld_rdata >> lo_sh);

        case (funct3)
            F3_B:    ext_data = {{24{merge_in[7]}}, merge_in[7:0]};
            F3_H:    ext_data = {{16{merge_in[15]}}, merge_in[15:0]};
            F3_BU:   ext_data = {24'h0, merge_in[7:0]};
            F3_HU:   ext_data = {16'h0, merge_in[15:0]};
            default: ext_data = merge_in;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store initiator for a word-wide dmem (sync byte-enable write,
// combinational read). Accepts one op at a time over req_valid/req_ready,
// splits misaligned ops into two word accesses, returns extended load data.
// - req_*  : core request (we, funct3, byte addr, right-justified wdata)
// - resp_* : one-cycle response pulse with rdata/err (held until next response)
// - wr_*   : dmem write port (word addr, lane data, byte enables)
// - rd_*   : dmem read port (word addr, read data)
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter bit          MISALIGN_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic [3:0]  wr_en,
    output logic [31:0] rd_addr,
    input  logic [31:0] rd_data
);

    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS * 4);

    lsu_state_e  state_q, state_d;
    logic        we_q, we_d, err_q, err_d, split_q, split_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, merge_q, merge_d;
    logic [3:0]  wr_en_q, wr_en_d;
    logic [31:0] wr_addr_q, wr_addr_d, wr_data_q, wr_data_d, rd_addr_q, rd_addr_d;
    logic        resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

    logic [2:0]  req_size;
    logic [32:0] last_byte;
    logic        f3_bad, range_bad, misal, req_split, req_err;
    logic [1:0]  cur_off;
    logic [2:0]  cur_f3;
    logic [31:0] cur_wdata;
    logic [3:0]  st_be;
    logic [31:0] st_data, merge_out, ext_data;

    // Access outputs are registered from the next state, so the request is
    // shaped straight from req_* on the accept edge and from op registers later.
    always_comb begin
        cur_off   = (state_q == IDLE) ? req_addr[1:0] : addr_q[1:0];
        cur_f3    = (state_q == IDLE) ? req_funct3    : f3_q;
        cur_wdata = (state_q == IDLE) ? req_wdata     : wdata_q;

        req_size  = size_bytes(req_funct3);
        f3_bad    = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                    (req_we && req_funct3[2]);
        last_byte = {1'b0, req_addr} + 33'(req_size) - 33'd1;
        range_bad = (last_byte >= LIMIT);
        misal     = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        req_split = (({1'b0, req_addr[1:0]} + req_size) > 3'd4);
        req_err   = f3_bad || range_bad || (misal && !MISALIGN_EN);
    end

    lsu_lane_align u_lane (
        .off       (cur_off),
        .funct3    (cur_f3),
        .st_hi     (state_q == ACC1),
        .st_wdata  (cur_wdata),
        .st_be     (st_be),
        .st_data   (st_data),
        .ld_hi     (state_q == ACC2),
        .ld_rdata  (rd_data),
        .merge_in  (merge_q),
        .merge_out (merge_out),
        .ext_data  (ext_data)
    );

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        f3_d         = f3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        err_d        = err_q;
        split_d      = split_q;
        merge_d      = merge_q;
        wr_en_d      = '0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        rd_addr_d    = rd_addr_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    err_d   = req_err;
                    split_d = req_split;
                    if (req_err) begin
                        state_d = RESP;
                    end else begin
                        state_d   = ACC1;
                        wr_addr_d = {req_addr[31:2], 2'b00};
                        rd_addr_d = {req_addr[31:2], 2'b00};
                        if (req_we) begin
                            wr_en_d   = st_be;
                            wr_data_d = st_data;
                        end
                    end
                end
            end
            ACC1: begin
                merge_d = merge_out;
                if (split_q) begin
                    state_d   = ACC2;
                    wr_addr_d = {addr_q[31:2] + 30'd1, 2'b00};
                    rd_addr_d = {addr_q[31:2] + 30'd1, 2'b00};
                    if (we_q) begin
                        wr_en_d   = st_be;
                        wr_data_d = st_data;
                    end
                end else begin
                    state_d = RESP;
                end
            end
            ACC2: begin
                merge_d = merge_out;
                state_d = RESP;
            end
            RESP: begin
                resp_valid_d = 1'b1;
                resp_rdata_d = (err_q || we_q) ? '0 : ext_data;
                resp_err_d   = err_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            f3_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            err_q        <= 1'b0;
            split_q      <= 1'b0;
            merge_q      <= '0;
            wr_en_q      <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            rd_addr_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            f3_q         <= f3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            err_q        <= err_d;
            split_q      <= split_d;
            merge_q      <= merge_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            rd_addr_q    <= rd_addr_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign rd_addr    = rd_addr_q;

endmodule
